// File: rtl/cpu_state_dumper.sv
// ============================================================================
// Module   : cpu_state_dumper
// Brief    : Detects the halt word, freezes the CPU and streams PC, data memory
//            and register bank out over a valid/ready port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_state_dumper #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          MEM_WORDS = 32,
    parameter int          REG_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic        cpu_hold_o,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [6:0]  dump_tag_o,
    output logic [31:0] dump_data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [4:0] c_MEM_LAST = 5'(MEM_WORDS - 1);
    localparam logic [4:0] c_REG_LAST = 5'(REG_WORDS - 1);
    localparam logic [6:0] c_REG_BASE = 7'(MEM_WORDS + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_SEND_PC  = 3'd2,
        ST_SEND_MEM = 3'd3,
        ST_SEND_REG = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic        r_valid;
    logic        r_hold;
    logic [6:0]  r_tag;
    logic [31:0] r_data;

    logic        w_load;
    logic [6:0]  w_mem_tag;
    logic [6:0]  w_reg_tag;

    // Output register is free when empty or being taken this edge.
    assign w_load    = !r_valid || dump_ready_i;
    assign w_mem_tag = {2'b00, r_idx} + 7'd1;
    assign w_reg_tag = {2'b00, r_idx} + c_REG_BASE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_hold  <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run_i && (instr_i == HALT_WORD)) begin
                        r_state <= ST_SETTLE;
                        r_hold  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    r_state <= ST_SEND_PC;
                end
                ST_SEND_PC: begin
                    if (w_load) begin
                        r_data  <= pc_i;
                        r_tag   <= '0;
                        r_valid <= 1'b1;
                        r_idx   <= '0;
                        r_state <= ST_SEND_MEM;
                    end
                end
                ST_SEND_MEM: begin
                    if (w_load) begin
                        r_data  <= mem_data_i;
                        r_tag   <= w_mem_tag;
                        r_valid <= 1'b1;
                        if (r_idx == c_MEM_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_SEND_REG;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                ST_SEND_REG: begin
                    if (w_load) begin
                        r_data  <= reg_data_i;
                        r_tag   <= w_reg_tag;
                        r_valid <= 1'b1;
                        if (r_idx == c_REG_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_valid || dump_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read ports only point at the bank currently being streamed.
    assign mem_addr_o   = (r_state == ST_SEND_MEM) ? r_idx : 5'd0;
    assign reg_addr_o   = (r_state == ST_SEND_REG) ? r_idx : 5'd0;
    assign cpu_hold_o   = r_hold;
    assign dump_valid_o = r_valid;
    assign dump_tag_o   = r_tag;
    assign dump_data_o  = r_data;
    assign busy_o       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_o       = (r_state == ST_DONE);

endmodule

`default_nettype wire
